// File: rtl/serdes_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : serdes_tx_framer
// Description : Transmit framer in front of a word serializer. After PLL lock
//               it sends a burst of TRAIN_WORDS training words, then streams
//               payload words from a 2-entry FIFO, filling gaps with
//               IDLE_PATTERN. Loss of lock returns to WAIT_LOCK and flushes
//               the FIFO; train_req in DATA re-runs the training burst.
// Ports       : clk        - word clock (shared with serializer)
//               reset      - synchronous, active-high
//               pll_lock   - PLL lock status (level)
//               train_req  - single-cycle retrain request (honoured in DATA)
//               in_data    - payload word
//               in_valid   - payload word valid
//               in_ready   - payload word accepted this cycle
//               word_out   - registered word to serializer D
//               load_word  - registered serializer LOAD_WORD strobe
//               training   - high while in TRAIN
//               link_up    - high while in DATA
// Revision    : 1.0 - initial release
// ============================================================================
module serdes_tx_framer #(
    parameter int               WIDTH         = 4,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(4'b0101),
    parameter logic [WIDTH-1:0] IDLE_PATTERN  = WIDTH'(4'b0011),
    parameter int               TRAIN_WORDS   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pll_lock,
    input  logic             train_req,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             load_word,
    output logic             training,
    output logic             link_up
);

    localparam logic [7:0] c_last_train = 8'(TRAIN_WORDS - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_TRAIN     = 2'd1,
        S_DATA      = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_next;
    logic [WIDTH-1:0] r_word_out;
    logic [WIDTH-1:0] w_word_next;
    logic             r_load;
    logic             w_load_next;

    // Payload FIFO (2 entries)
    logic [WIDTH-1:0] r_mem [0:1];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    logic w_in_ready;
    logic w_push;
    logic w_emit;
    logic w_pop;
    logic w_bypass;
    logic w_flush;
    logic w_store;

    // Ready depends only on registered state and occupancy, never on in_valid.
    assign w_in_ready = (r_state != S_WAIT_LOCK) && (r_count < 2'd2);
    assign w_push     = in_valid & w_in_ready;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_word_next  = '0;
        w_load_next  = 1'b0;
        w_emit       = 1'b0;
        w_flush      = 1'b0;
        w_pop        = 1'b0;
        w_bypass     = 1'b0;

        // Lock loss wins over everything, including train_req.
        if (!pll_lock) begin
            w_state_next = S_WAIT_LOCK;
            w_cnt_next   = '0;
            w_flush      = 1'b1;
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    w_state_next = S_TRAIN;
                    w_cnt_next   = '0;
                    w_word_next  = TRAIN_PATTERN;
                    w_load_next  = 1'b1;
                end
                S_TRAIN: begin
                    // r_cnt = training words already sent before this cycle's word
                    if (r_cnt == c_last_train) begin
                        w_state_next = S_DATA;
                        w_emit       = 1'b1;
                    end else begin
                        w_cnt_next  = r_cnt + 8'd1;
                        w_word_next = TRAIN_PATTERN;
                        w_load_next = 1'b1;
                    end
                end
                S_DATA: begin
                    if (train_req) begin
                        w_state_next = S_TRAIN;
                        w_cnt_next   = '0;
                        w_word_next  = TRAIN_PATTERN;
                        w_load_next  = 1'b1;
                    end else begin
                        w_emit = 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_WAIT_LOCK;
                    w_cnt_next   = '0;
                end
            endcase
        end

        // Next cycle is a DATA cycle: send FIFO head, or pass an incoming word
        // straight through when the FIFO is empty, otherwise idle.
        if (w_emit) begin
            w_load_next = 1'b1;
            if (r_count != 2'd0) begin
                w_word_next = r_mem[r_rd_ptr];
                w_pop       = 1'b1;
            end else if (w_push) begin
                w_word_next = in_data;
                w_bypass    = 1'b1;
            end else begin
                w_word_next = IDLE_PATTERN;
            end
        end
    end

    assign w_store = w_push & ~w_flush & ~w_bypass;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_WAIT_LOCK;
            r_cnt      <= '0;
            r_word_out <= '0;
            r_load     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_word_out <= w_word_next;
            r_load     <= w_load_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (w_flush && !reset)) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_store) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign word_out  = r_word_out;
    assign load_word = r_load;
    assign training  = (r_state == S_TRAIN);
    assign link_up   = (r_state == S_DATA);

endmodule
`default_nettype wire

// File: tb/tb_serdes_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serdes_tx_framer
// Description : Directed and randomized self-checking bench for
//               serdes_tx_framer (WIDTH=4, TRAIN=0101, IDLE=0011, 16 words).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serdes_tx_framer;

    localparam logic [3:0] c_train = 4'b0101;
    localparam logic [3:0] c_idle  = 4'b0011;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       train_req;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] word_out;
    logic       load_word;
    logic       training;
    logic       link_up;

    int checks = 0;
    int errors = 0;

    serdes_tx_framer dut (
        .clk       (clk),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .train_req (train_req),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .word_out  (word_out),
        .load_word (load_word),
        .training  (training),
        .link_up   (link_up)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are applied at the falling edge, consumed at the rising edge,
    // and outputs are observed at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_word"},  32'(word_out),  32'h0);
        chk({tag, "_load"},  32'(load_word), 32'h0);
        chk({tag, "_ready"}, 32'(in_ready),  32'h0);
        chk({tag, "_train"}, 32'(training),  32'h0);
        chk({tag, "_up"},    32'(link_up),   32'h0);
    endtask

    task automatic run_training(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_training"}, 32'(training),  32'h1);
            chk({tag, "_tword"},    32'(word_out),  32'(c_train));
            chk({tag, "_tload"},    32'(load_word), 32'h1);
            tick();
        end
        chk({tag, "_linkup"}, 32'(link_up),  32'h1);
        chk({tag, "_notrn"},  32'(training), 32'h0);
    endtask

    logic [3:0] q[$];
    logic       hold;
    logic       acc;

    initial begin
        reset = 1'b1; pll_lock = 1'b0; train_req = 1'b0; in_data = '0; in_valid = 1'b0;
        @(negedge clk);
        tick();
        chk_all_zero("reset");

        // Reset overrides lock
        pll_lock = 1'b1; in_valid = 1'b1;
        tick();
        chk_all_zero("reset_ovr");

        // Bring-up: 16 training words then idle
        reset = 1'b0; in_valid = 1'b0;
        chk("wl_ready", 32'(in_ready), 32'h0);
        tick();
        chk("train_ready", 32'(in_ready), 32'h1);
        run_training("bringup");
        chk("bringup_idle", 32'(word_out), 32'(c_idle));
        chk("bringup_load", 32'(load_word), 32'h1);

        // Two back-to-back words with one-cycle latency
        in_valid = 1'b1; in_data = 4'hA;
        chk("data_ready", 32'(in_ready), 32'h1);
        tick();
        chk("lat_A", 32'(word_out), 32'hA);
        in_data = 4'h5;
        tick();
        chk("lat_5", 32'(word_out), 32'h5);
        in_valid = 1'b0;
        tick();
        chk("lat_idle", 32'(word_out), 32'(c_idle));

        // Retrain with in_valid held high; words queue and emerge in order
        in_valid = 1'b1; in_data = 4'h1;
        tick();
        chk("pre_rt_word", 32'(word_out), 32'h1);
        in_data = 4'h6; train_req = 1'b1;
        tick();
        chk("rt_training", 32'(training), 32'h1);
        chk("rt_word", 32'(word_out), 32'(c_train));
        train_req = 1'b0; in_data = 4'h7;
        chk("rt_ready1", 32'(in_ready), 32'h1);
        tick();
        in_data = 4'h9;
        for (int i = 2; i <= 16; i++) begin
            train_req = (i == 5);
            chk("rt_full_ready", 32'(in_ready), 32'h0);
            chk("rt_train_hold", 32'(training), 32'h1);
            tick();
        end
        train_req = 1'b0;
        chk("rt_up", 32'(link_up), 32'h1);
        chk("rt_first", 32'(word_out), 32'h6);
        in_valid = 1'b0;
        tick();
        chk("rt_second", 32'(word_out), 32'h7);
        tick();
        chk("rt_idle", 32'(word_out), 32'(c_idle));

        // Lock loss at training count 7 with two words queued
        train_req = 1'b1; in_valid = 1'b1; in_data = 4'h6;
        tick();
        train_req = 1'b0; in_data = 4'h7;
        tick();
        in_valid = 1'b0;
        chk("ll_full", 32'(in_ready), 32'h0);
        for (int i = 0; i < 6; i++) tick();
        pll_lock = 1'b0;
        tick();
        chk_all_zero("lockloss");
        pll_lock = 1'b1;
        tick();
        run_training("relock");
        chk("relock_flushed", 32'(word_out), 32'(c_idle));
        tick();
        chk("relock_flushed2", 32'(word_out), 32'(c_idle));

        // Reset with a full FIFO
        train_req = 1'b1; in_valid = 1'b1; in_data = 4'h6;
        tick();
        train_req = 1'b0; in_data = 4'h7;
        tick();
        in_valid = 1'b0;
        chk("rs_full", 32'(in_ready), 32'h0);
        reset = 1'b1;
        tick();
        chk_all_zero("rs_mid");
        reset = 1'b0;
        tick();
        run_training("rs_after");
        chk("rs_no_stale", 32'(word_out), 32'(c_idle));

        // Randomized traffic against a queue scoreboard
        hold = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            pll_lock  = ($urandom_range(0, 199) != 0);
            train_req = ($urandom_range(0, 49) == 0);
            if (!hold) begin
                in_valid = ($urandom_range(0, 1) == 1);
                in_data  = 4'($urandom);
            end
            acc = in_valid && in_ready && pll_lock;
            if (acc) q.push_back(in_data);
            if (!pll_lock) q.delete();
            hold = in_valid && !acc && pll_lock;
            tick();
            if (link_up) begin
                chk("rnd_load", 32'(load_word), 32'h1);
                if (q.size() != 0) chk("rnd_payload", 32'(word_out), 32'(q.pop_front()));
                else chk("rnd_idle", 32'(word_out), 32'(c_idle));
            end else if (training) begin
                chk("rnd_train", 32'(word_out), 32'(c_train));
            end else begin
                chk("rnd_wait", 32'(word_out), 32'h0);
                chk("rnd_wait_load", 32'(load_word), 32'h0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
